// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  i_req_valid;
  logic [ADDR_W-1:0]     i_req_addr;
  logic                  i_req_ready;
  logic                  i_resp_valid;
  logic [DATA_W-1:0]     i_resp_rdata;

  logic                  d_req_valid;
  logic [ADDR_W-1:0]     d_req_addr;
  logic                  d_req_wen;
  logic [DATA_W/8-1:0]   d_req_wmask;
  logic [DATA_W-1:0]     d_req_wdata;
  logic                  d_req_ready;
  logic                  d_resp_valid;
  logic [DATA_W-1:0]     d_resp_rdata;

  logic                  resp_err;

  logic                  mem_req_valid;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_wen;
  logic [DATA_W/8-1:0]   mem_req_wmask;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_resp_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wmask, d_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output i_req_ready, i_resp_valid, i_resp_rdata,
    output d_req_ready, d_resp_valid, d_resp_rdata, resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wmask, d_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  i_req_ready, i_resp_valid, i_resp_rdata,
    input  d_req_ready, d_resp_valid, d_resp_rdata, resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// in flight, data priority with a streak limit, and a WAIT timeout that returns an error.
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          debug_arb_state,
  output logic                debug_owner
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TCNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state;
  logic                owner_q;
  logic [STREAK_W-1:0] streak;
  logic [TCNT_W-1:0]   tcnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                i_resp_vld_q;
  logic                d_resp_vld_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic                grant_i;
  logic                grant_d;
  logic                rsp_done;
  logic [DATA_W-1:0]   rsp_data;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] s);
    return (s == STREAK_MAX) ? s : s + 1'b1;
  endfunction

  // Readies are gated by rst so every output is 0 while reset is held.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == ST_IDLE && !rst) begin
      if (bus.d_req_valid && !(bus.i_req_valid && streak == STREAK_MAX))
        grant_d = 1'b1;
      else if (bus.i_req_valid)
        grant_i = 1'b1;
    end
  end

  // A real response on the last timeout cycle takes precedence over the error.
  assign rsp_done = bus.mem_resp_valid || (tcnt == TCNT_LAST);
  assign rsp_data = (bus.mem_resp_valid && !wen_q) ? bus.mem_resp_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner_q      <= 1'b0;
      streak       <= '0;
      tcnt         <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wmask_q      <= '0;
      wdata_q      <= '0;
      i_resp_vld_q <= 1'b0;
      d_resp_vld_q <= 1'b0;
      resp_err_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      i_resp_vld_q <= 1'b0;
      d_resp_vld_q <= 1'b0;
      resp_err_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            owner_q <= 1'b1;
            addr_q  <= bus.d_req_addr;
            wen_q   <= bus.d_req_wen;
            wmask_q <= bus.d_req_wmask;
            wdata_q <= bus.d_req_wdata;
            streak  <= bus.i_req_valid ? sat_inc(streak) : '0;
            state   <= ST_REQ;
          end else if (grant_i) begin
            owner_q <= 1'b0;
            addr_q  <= bus.i_req_addr;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            streak  <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            tcnt  <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rsp_done) begin
            resp_err_q <= !bus.mem_resp_valid;
            if (owner_q) begin
              d_resp_vld_q <= 1'b1;
              d_rdata_q    <= rsp_data;
            end else begin
              i_resp_vld_q <= 1'b1;
              i_rdata_q    <= rsp_data;
            end
            state <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.i_req_ready   = grant_i;
  assign bus.d_req_ready   = grant_d;
  assign bus.i_resp_valid  = i_resp_vld_q;
  assign bus.i_resp_rdata  = i_rdata_q;
  assign bus.d_resp_valid  = d_resp_vld_q;
  assign bus.d_resp_rdata  = d_rdata_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.mem_req_valid = (state == ST_REQ);
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_wmask = wmask_q;
  assign bus.mem_req_wdata = wdata_q;
  assign debug_arb_state   = state;
  assign debug_owner       = owner_q;

endmodule
